booth_datapath: RTL and testbench



---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_addsub.sv | 20 ++
 rtl/booth_datapath.sv | 103 ++++++++++
 tb/tb_booth_datapath.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared mode encodings for the Booth multiplier datapath and its controller.
package booth_pkg;

   localparam logic [1:0] A_HOLD = 2'b00;
   localparam logic [1:0] A_ASR  = 2'b01;
   localparam logic [1:0] A_LOAD = 2'b10;
   localparam logic [1:0] A_CLR  = 2'b11;

   localparam logic [1:0] Q_HOLD = 2'b00;
   localparam logic [1:0] Q_SHR  = 2'b01;
   localparam logic [1:0] Q_LOAD = 2'b10;
   localparam logic [1:0] Q_CLR  = 2'b11;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/booth_addsub.sv
// Combinational WIDTH-bit two's-complement adder/subtractor; overflow wraps.
module booth_addsub
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = a + b;
      if (op == ALU_SUB) begin
         result = a - b;
      end
   end

endmodule

// File: rtl/booth_datapath.sv
// Booth multiplier datapath: A, Q, Q_-1, M and iteration counter driven by
// per-cycle mode bits from the controller; every output is a register read.
module booth_datapath
   import booth_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic               a1,
   input  logic               a2,
   input  logic               q1,
   input  logic               q2,
   input  logic               m1,
   input  logic               alu,
   input  logic               count,
   output logic               c1,
   output logic               c2,
   output logic               cnt_zero,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] m_reg;
   logic             q_m1;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] alu_result;
   logic [1:0]       a_mode;
   logic [1:0]       q_mode;

   assign a_mode = {a1, a2};
   assign q_mode = {q1, q2};

   booth_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a      (a_reg),
      .b      (m_reg),
      .op     (alu),
      .result (alu_result)
   );

   // Q shifts in the pre-edge A[0], so A=LOAD with Q=SHR never sees the ALU result.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg <= '0;
         q_reg <= '0;
         q_m1  <= 1'b0;
         m_reg <= '0;
      end else begin
         case (a_mode)
            A_ASR:   a_reg <= {a_reg[WIDTH-1], a_reg[WIDTH-1:1]};
            A_LOAD:  a_reg <= alu_result;
            A_CLR:   a_reg <= '0;
            default: a_reg <= a_reg;
         endcase
         case (q_mode)
            Q_SHR: begin
               q_reg <= {a_reg[0], q_reg[WIDTH-1:1]};
               q_m1  <= q_reg[0];
            end
            Q_LOAD: begin
               q_reg <= multiplier;
               q_m1  <= 1'b0;
            end
            Q_CLR: begin
               q_reg <= '0;
               q_m1  <= 1'b0;
            end
            default: begin
               q_reg <= q_reg;
               q_m1  <= q_m1;
            end
         endcase
         if (m1) begin
            m_reg <= multiplicand;
         end
      end
   end

   // A Q load re-arms the counter even when a decrement is requested; it saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (q_mode == Q_LOAD) begin
         cnt <= CNT_INIT;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign c1       = q_reg[0];
   assign c2       = q_m1;
   assign cnt_zero = (cnt == '0);
   assign busy     = (cnt != '0);
   assign product  = {a_reg, q_reg};

endmodule

// File: tb/tb_booth_datapath.sv
// Scoreboard bench for booth_datapath: stimulus queues hand-computed state,
// a negedge monitor pops and compares it against the registered outputs.
module tb_booth_datapath;
   import booth_pkg::*;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [2*WIDTH-1:0] product;
      logic               c1;
      logic               c2;
      logic               cnt_zero;
      logic               busy;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic [1:0]         a_mode;
   logic [1:0]         q_mode;
   logic               m1;
   logic               alu;
   logic               count;
   logic               c1;
   logic               c2;
   logic               cnt_zero;
   logic [2*WIDTH-1:0] product;
   logic               busy;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;

   booth_datapath #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .a1           (a_mode[1]),
      .a2           (a_mode[0]),
      .q1           (q_mode[1]),
      .q2           (q_mode[0]),
      .m1           (m1),
      .alu          (alu),
      .count        (count),
      .c1           (c1),
      .c2           (c2),
      .cnt_zero     (cnt_zero),
      .product      (product),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic compareField(input string tag, input string field,
                               input logic [2*WIDTH-1:0] act, input logic [2*WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s.%s actual=%h required=%h", tag, field, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e, input string tag);
      compareField(tag, "product",  product, e.product);
      compareField(tag, "c1",       {15'd0, c1}, {15'd0, e.c1});
      compareField(tag, "c2",       {15'd0, c2}, {15'd0, e.c2});
      compareField(tag, "cnt_zero", {15'd0, cnt_zero}, {15'd0, e.cnt_zero});
      compareField(tag, "busy",     {15'd0, busy}, {15'd0, e.busy});
   endtask

   // Monitor: the DUT presents a new state every edge; compare whatever is queued.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         checkOutput(exp_q.pop_front(), tag_q.pop_front());
      end
   end

   // Drives one cycle of modes, then returns just after the active edge.
   task automatic applyStimulus(input logic [1:0] am, input logic [1:0] qm, input logic m1_in,
                                input logic alu_in, input logic count_in, input logic rst_in);
      @(negedge clk);
      a_mode = am;
      q_mode = qm;
      m1     = m1_in;
      alu    = alu_in;
      count  = count_in;
      rst    = rst_in;
      @(posedge clk);
      #1;
   endtask

   task automatic expectState(input string tag, input logic [2*WIDTH-1:0] p, input logic e_c1,
                              input logic e_c2, input logic e_cz, input logic e_busy);
      exp_t e;
      e.product  = p;
      e.c1       = e_c1;
      e.c2       = e_c2;
      e.cnt_zero = e_cz;
      e.busy     = e_busy;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // Plays the controller role; operation choice comes from the known multiplier bits.
   task automatic runMultiply(input logic [WIDTH-1:0] mc, input logic [WIDTH-1:0] mp,
                              input logic [2*WIDTH-1:0] exp_prod, input int iters, input string tag);
      logic cur;
      logic prev;
      multiplicand = mc;
      multiplier   = mp;
      applyStimulus(A_CLR, Q_LOAD, 1'b1, ALU_ADD, 1'b0, 1'b0);
      for (int i = 0; i < iters; i++) begin
         cur  = mp[i];
         prev = (i == 0) ? 1'b0 : mp[i-1];
         if (cur && !prev) applyStimulus(A_LOAD, Q_HOLD, 1'b0, ALU_SUB, 1'b0, 1'b0);
         if (!cur && prev) applyStimulus(A_LOAD, Q_HOLD, 1'b0, ALU_ADD, 1'b0, 1'b0);
         applyStimulus(A_ASR, Q_SHR, 1'b0, ALU_ADD, 1'b1, 1'b0);
      end
      if (iters == WIDTH) begin
         expectState(tag, exp_prod, exp_prod[0], mp[WIDTH-1], 1'b1, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1; a_mode = '0; q_mode = '0; m1 = 1'b0; alu = 1'b0; count = 1'b0;
      multiplicand = '0; multiplier = '0;

      // Reset wins over random modes
      for (int i = 0; i < 2; i++) begin
         multiplicand = WIDTH'($urandom);
         multiplier   = WIDTH'($urandom);
         applyStimulus(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         expectState("reset", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Load, then one hand-computed Booth step
      multiplicand = 8'h03;
      multiplier   = 8'h0B;
      applyStimulus(A_HOLD, Q_LOAD, 1'b1, ALU_ADD, 1'b0, 1'b0);
      expectState("load", 16'h000B, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(A_LOAD, Q_HOLD, 1'b0, ALU_SUB, 1'b0, 1'b0);
      expectState("alu_sub", 16'hFD0B, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(A_ASR, Q_SHR, 1'b0, ALU_ADD, 1'b1, 1'b0);
      expectState("shift", 16'hFE85, 1'b1, 1'b1, 1'b0, 1'b1);

      // Full multiplies, including the most negative multiplier
      runMultiply(8'h03, 8'hFB, 16'hFFF1, WIDTH, "mul_3x-5");
      runMultiply(8'h7F, 8'h80, 16'hC080, WIDTH, "mul_127x-128");
      runMultiply(8'h81, 8'h80, 16'h3F80, WIDTH, "mul_-127x-128");

      // Counter saturation after a load
      multiplier = 8'h5A;
      applyStimulus(A_CLR, Q_LOAD, 1'b0, ALU_ADD, 1'b0, 1'b0);
      expectState("sat_load", 16'h005A, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(A_HOLD, Q_HOLD, 1'b0, ALU_ADD, 1'b1, 1'b0);
         expectState($sformatf("sat_%0d", k), 16'h005A, 1'b0, 1'b0, (k >= WIDTH), (k < WIDTH));
      end

      // Load beats a simultaneous decrement
      multiplier = 8'h33;
      applyStimulus(A_HOLD, Q_LOAD, 1'b0, ALU_ADD, 1'b1, 1'b0);
      expectState("load_wins", 16'h0033, 1'b1, 1'b0, 1'b0, 1'b1);

      // Abort mid-multiply, then a clean run
      runMultiply(8'h03, 8'hFB, 16'h0000, 4, "abort");
      applyStimulus(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      expectState("mid_reset", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      runMultiply(8'h07, 8'h07, 16'h0031, WIDTH, "mul_7x7");

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
      end
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
